// File: rtl/seq_det_pkg.sv
// Shared constants, per-channel context type and helpers for the time-shared sequence detector.
// Optional match counters are enabled with the SEQ_DET_MATCH_CNT_EN macro (see seq_det_scheduler).
package seq_det_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_PAT_W  = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1011;
    localparam int CNT_W      = 8;
    localparam int CH_W       = $clog2(DEF_NUM_CH);

    // Context is sized for the largest supported pattern so one type serves every PAT_W.
    localparam int MAX_PAT_W  = 8;
    localparam int HIST_W     = MAX_PAT_W - 1;
    localparam int FILL_W     = $clog2(MAX_PAT_W);

    typedef struct packed {
        logic [HIST_W-1:0] hist;
        logic [FILL_W-1:0] fill;
    } ctx_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/seq_det_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from pointer+1, pointer moves to the
// granted index only when a grant is actually issued (en_i high and some request present).
module seq_det_rr_arbiter #(
    parameter int NUM_CH = 4,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [NUM_CH-1:0] req_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [SEL_W-1:0]  gnt_idx_o,
    output logic              accept_o
);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] idx;
    logic             found;

    always_comb begin
        int pos;
        pos   = 0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            pos = (int'(ptr_q) + i) % NUM_CH;
            if (!found && req_i[SEL_W'(pos)]) begin
                found = 1'b1;
                idx   = SEL_W'(pos);
            end
        end
        gnt_o = '0;
        if (found && en_i) begin
            gnt_o[idx] = 1'b1;
        end
        accept_o  = found && en_i;
        gnt_idx_o = idx;
        ptr_d     = accept_o ? idx : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= SEL_W'(NUM_CH - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// One Mealy pattern detector time-shared among NUM_CH bit streams via round-robin arbitration.
// Define SEQ_DET_MATCH_CNT_EN to add per-channel 8-bit saturating match counters on cnt_sel/cnt_out.
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int PAT_W  = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int OVERLAP = 1,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_load,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [NUM_CH-1:0] ch_valid,
    input  logic [NUM_CH-1:0] ch_bit,
    output logic [NUM_CH-1:0] ch_ready,
    output logic              match_valid,
    output logic [SEL_W-1:0]  match_ch,
    input  logic [SEL_W-1:0]  cnt_sel,
    output logic [CNT_W-1:0]  cnt_out
);

    logic             accept;
    logic [SEL_W-1:0] gnt_idx;

    // cfg_load blocks every grant so no bit is consumed while contexts are being cleared.
    seq_det_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (!cfg_load),
        .req_i     (ch_valid),
        .gnt_o     (ch_ready),
        .gnt_idx_o (gnt_idx),
        .accept_o  (accept)
    );

    ctx_t             ctx_q [NUM_CH];
    ctx_t             ctx_d [NUM_CH];
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic             match_valid_q, match_valid_d;
    logic [SEL_W-1:0] match_ch_q, match_ch_d;

    ctx_t             cur;
    logic             cur_bit;
    logic [PAT_W-1:0] window;
    logic             fill_full;
    logic             hit;

    always_comb begin
        cur       = ctx_q[gnt_idx];
        cur_bit   = ch_bit[gnt_idx];
        window    = {cur.hist[PAT_W-2:0], cur_bit};
        fill_full = (cur.fill == FILL_W'(PAT_W - 1));
        hit       = accept && fill_full && (window == pattern_q);
    end

    always_comb begin
        ctx_d         = ctx_q;
        pattern_d     = pattern_q;
        match_valid_d = 1'b0;
        match_ch_d    = match_ch_q;
        if (cfg_load) begin
            pattern_d = cfg_pattern;
            for (int i = 0; i < NUM_CH; i++) begin
                ctx_d[i] = '0;
            end
        end else if (accept) begin
            match_valid_d = hit;
            match_ch_d    = gnt_idx;
            if (hit && (OVERLAP == 0)) begin
                ctx_d[gnt_idx] = '0;
            end else begin
                ctx_d[gnt_idx].hist = HIST_W'(window[PAT_W-2:0]);
                if (!fill_full) begin
                    ctx_d[gnt_idx].fill = cur.fill + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ctx_q[i] <= '0;
            end
            pattern_q     <= PATTERN;
            match_valid_q <= 1'b0;
            match_ch_q    <= '0;
        end else begin
            ctx_q         <= ctx_d;
            pattern_q     <= pattern_d;
            match_valid_q <= match_valid_d;
            match_ch_q    <= match_ch_d;
        end
    end

    assign match_valid = match_valid_q;
    assign match_ch    = match_ch_q;

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];

    always_comb begin
        cnt_d = cnt_q;
        if (cfg_load) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_d[i] = '0;
            end
        end else if (hit) begin
            cnt_d[gnt_idx] = sat_inc(cnt_q[gnt_idx]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Selects beyond the last channel (non-power-of-two NUM_CH) read as zero.
    always_comb begin
        cnt_out = '0;
        if ({1'b0, cnt_sel} < (SEL_W + 1)'(NUM_CH)) begin
            cnt_out = cnt_q[cnt_sel];
        end
    end
`else
    logic unused_cnt_sel;
    assign unused_cnt_sel = ^cnt_sel;
    assign cnt_out        = '0;
`endif

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed bench for seq_det_scheduler: one overlapping and one non-overlapping instance share stimulus.
module tb_seq_det_scheduler;

    logic       clk;
    logic       rst_n;
    logic       cfg_load;
    logic [3:0] cfg_pattern;
    logic [3:0] ch_valid;
    logic [3:0] ch_bit;
    logic [1:0] cnt_sel;

    logic [3:0] ch_ready,    ch_ready0;
    logic       match_valid, match_valid0;
    logic [1:0] match_ch,    match_ch0;
    logic [7:0] cnt_out,     cnt_out0;

    int total = 0;
    int bad   = 0;

    seq_det_scheduler #(.NUM_CH(4), .PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .ch_valid(ch_valid), .ch_bit(ch_bit), .ch_ready(ch_ready),
        .match_valid(match_valid), .match_ch(match_ch),
        .cnt_sel(cnt_sel), .cnt_out(cnt_out)
    );

    seq_det_scheduler #(.NUM_CH(4), .PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .ch_valid(ch_valid), .ch_bit(ch_bit), .ch_ready(ch_ready0),
        .match_valid(match_valid0), .match_ch(match_ch0),
        .cnt_sel(cnt_sel), .cnt_out(cnt_out0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = 4'h0;
        ch_valid    = 4'h0;
        ch_bit      = 4'h0;
        cnt_sel     = 2'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Present one bit on one channel for a single clock edge.
    task automatic send(input int ch, input logic b);
        ch_valid = 4'(1 << ch);
        ch_bit   = b ? 4'(1 << ch) : 4'h0;
        tick();
        ch_valid = 4'h0;
        ch_bit   = 4'h0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (match_valid !== 1'b0) begin
            bad++; $display("FAIL reset_match_valid got=%0b exp=0", match_valid);
        end
        total++;
        if (match_ch !== 2'd0) begin
            bad++; $display("FAIL reset_match_ch got=%0d exp=0", match_ch);
        end
        total++;
        if (ch_ready !== 4'b0000) begin
            bad++; $display("FAIL reset_ready_idle got=%b exp=0000", ch_ready);
        end
        ch_valid = 4'b1111;
        #1;
        total++;
        if (ch_ready !== 4'b0001) begin
            bad++; $display("FAIL reset_first_grant got=%b exp=0001", ch_ready);
        end
        ch_valid = 4'b0000;
        total++;
        if (cnt_out !== 8'd0) begin
            bad++; $display("FAIL reset_cnt_out got=%0d exp=0", cnt_out);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] stream;
        logic [6:0] exp_ov;
        logic [6:0] exp_no;
        stream = 7'b1011011;
        exp_ov = 7'b0001001;
        exp_no = 7'b0001000;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            send(0, stream[6-k]);
            total++;
            if (match_valid !== exp_ov[6-k]) begin
                bad++; $display("FAIL overlap_match bit%0d got=%0b exp=%0b", k + 1, match_valid, exp_ov[6-k]);
            end
            total++;
            if (match_valid0 !== exp_no[6-k]) begin
                bad++; $display("FAIL nooverlap_match bit%0d got=%0b exp=%0b", k + 1, match_valid0, exp_no[6-k]);
            end
            if (exp_ov[6-k]) begin
                total++;
                if (match_ch !== 2'd0) begin
                    bad++; $display("FAIL overlap_match_ch bit%0d got=%0d exp=0", k + 1, match_ch);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] pat;
        logic [3:0] exp_rdy;
        logic       exp_mv;
        pat = 4'b1011;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            ch_valid = 4'b1111;
            ch_bit   = pat[3 - k/4] ? 4'b1111 : 4'b0000;
            exp_rdy  = 4'(1 << (k % 4));
            #1;
            total++;
            if (ch_ready !== exp_rdy) begin
                bad++; $display("FAIL rr_ready cyc%0d got=%b exp=%b", k, ch_ready, exp_rdy);
            end
            tick();
            exp_mv = (k >= 12);
            total++;
            if (match_valid !== exp_mv) begin
                bad++; $display("FAIL rr_match_valid cyc%0d got=%0b exp=%0b", k, match_valid, exp_mv);
            end
            if (exp_mv) begin
                total++;
                if (match_ch !== 2'(k % 4)) begin
                    bad++; $display("FAIL rr_match_ch cyc%0d got=%0d exp=%0d", k, match_ch, k % 4);
                end
            end
        end
        ch_valid = 4'b0000;
        ch_bit   = 4'b0000;
    endtask

    task automatic test_cfg_load();
        logic [3:0] post;
        logic [3:0] exp_m;
        do_reset();
        send(2, 1'b1);
        send(2, 1'b0);
        send(2, 1'b1);
        cfg_load    = 1'b1;
        cfg_pattern = 4'b0110;
        ch_valid    = 4'b0100;
        ch_bit      = 4'b0100;
        #1;
        total++;
        if (ch_ready !== 4'b0000) begin
            bad++; $display("FAIL cfg_ready_blocked got=%b exp=0000", ch_ready);
        end
        tick();
        cfg_load = 1'b0;
        ch_valid = 4'b0000;
        ch_bit   = 4'b0000;
        total++;
        if (match_valid !== 1'b0) begin
            bad++; $display("FAIL cfg_no_match_after_load got=%0b exp=0", match_valid);
        end
        send(2, 1'b1);
        total++;
        if (match_valid !== 1'b0) begin
            bad++; $display("FAIL cfg_history_cleared got=%0b exp=0", match_valid);
        end
        post  = 4'b0110;
        exp_m = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            send(2, post[3-k]);
            total++;
            if (match_valid !== exp_m[3-k]) begin
                bad++; $display("FAIL cfg_new_pattern bit%0d got=%0b exp=%0b", k, match_valid, exp_m[3-k]);
            end
        end
        total++;
        if (match_ch !== 2'd2) begin
            bad++; $display("FAIL cfg_new_pattern_ch got=%0d exp=2", match_ch);
        end
        // A match registered just before a load is still visible during the load cycle.
        cfg_load    = 1'b1;
        cfg_pattern = 4'b1011;
        #1;
        total++;
        if (match_valid !== 1'b1) begin
            bad++; $display("FAIL cfg_prior_match_held got=%0b exp=1", match_valid);
        end
        tick();
        cfg_load = 1'b0;
        total++;
        if (match_valid !== 1'b0) begin
            bad++; $display("FAIL cfg_pulse_single got=%0b exp=0", match_valid);
        end
    endtask

    task automatic test_cfg_pointer();
        do_reset();
        cfg_load    = 1'b1;
        cfg_pattern = 4'b1011;
        ch_valid    = 4'b0011;
        #1;
        total++;
        if (ch_ready !== 4'b0000) begin
            bad++; $display("FAIL cfgptr_ready_blocked got=%b exp=0000", ch_ready);
        end
        tick();
        cfg_load = 1'b0;
        total++;
        if (match_valid !== 1'b0) begin
            bad++; $display("FAIL cfgptr_match_valid got=%0b exp=0", match_valid);
        end
        #1;
        total++;
        if (ch_ready !== 4'b0001) begin
            bad++; $display("FAIL cfgptr_pointer_held got=%b exp=0001", ch_ready);
        end
        tick();
        total++;
        if (ch_ready !== 4'b0010) begin
            bad++; $display("FAIL cfgptr_pointer_advance got=%b exp=0010", ch_ready);
        end
        ch_valid = 4'b0000;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        send(0, 1'b1);
        send(0, 1'b0);
        send(0, 1'b1);
        do_reset();
        send(0, 1'b1);
        total++;
        if (match_valid !== 1'b0) begin
            bad++; $display("FAIL midreset_history_discarded got=%0b exp=0", match_valid);
        end
    endtask

    task automatic test_counter();
        int         nm;
        logic [7:0] exp_after_first;
        logic [7:0] exp_sat;
`ifdef SEQ_DET_MATCH_CNT_EN
        exp_after_first = 8'd1;
        exp_sat         = 8'd255;
`else
        exp_after_first = 8'd0;
        exp_sat         = 8'd0;
`endif
        do_reset();
        nm = 0;
        cnt_sel = 2'd1;
        send(1, 1'b1);
        send(1, 1'b0);
        send(1, 1'b1);
        send(1, 1'b1);
        if (match_valid) nm++;
        #1;
        total++;
        if (cnt_out !== exp_after_first) begin
            bad++; $display("FAIL cnt_first_hit got=%0d exp=%0d", cnt_out, exp_after_first);
        end
        for (int r = 0; r < 299; r++) begin
            send(1, 1'b0);
            if (match_valid) nm++;
            send(1, 1'b1);
            if (match_valid) nm++;
            send(1, 1'b1);
            if (match_valid) nm++;
        end
        total++;
        if (nm !== 300) begin
            bad++; $display("FAIL cnt_match_pulses got=%0d exp=300", nm);
        end
        #1;
        total++;
        if (cnt_out !== exp_sat) begin
            bad++; $display("FAIL cnt_saturate_ch1 got=%0d exp=%0d", cnt_out, exp_sat);
        end
        cnt_sel = 2'd0;
        #1;
        total++;
        if (cnt_out !== 8'd0) begin
            bad++; $display("FAIL cnt_other_ch0 got=%0d exp=0", cnt_out);
        end
        cnt_sel     = 2'd1;
        cfg_load    = 1'b1;
        cfg_pattern = 4'b1011;
        tick();
        cfg_load = 1'b0;
        #1;
        total++;
        if (cnt_out !== 8'd0) begin
            bad++; $display("FAIL cnt_cleared_by_load got=%0d exp=0", cnt_out);
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_round_robin();
        test_cfg_load();
        test_cfg_pointer();
        test_reset_midstream();
        test_counter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
